// File: rtl/soc_system_pio_capture_if.sv
// Avalon-MM slave bus for the capture PIO.
// Word addressed, single-cycle writes, registered reads.
interface soc_system_pio_capture_if;
  logic [3:0]  address;
  logic        chipselect;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/soc_system_pio_capture.sv
// Multi-channel input PIO with per-bit edge capture,
// write-1-to-clear capture bits and a maskable level irq.
module soc_system_pio_capture #(
  parameter int NUM_CH    = 4,
  parameter int DATA_W    = 32,
  parameter int EDGE_TYPE = 0,
  parameter int SYNC_EN   = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  soc_system_pio_capture_if.slave  bus,
  input  logic [NUM_CH*DATA_W-1:0] in_port,
  output logic                     irq
);

  localparam int MAXC = 4;

  localparam logic [1:0] BANK_DATA = 2'b00;
  localparam logic [1:0] BANK_MASK = 2'b01;
  localparam logic [1:0] BANK_EC   = 2'b10;
  localparam logic [1:0] BANK_STAT = 2'b11;

  typedef logic [DATA_W-1:0] word_t;

  logic [1:0] bank;
  logic [1:0] ch;
  logic       wr_en;
  logic [1:0] prime;
  logic       edge_en;
  logic [31:0] rd_n;

  logic [MAXC-1:0][DATA_W-1:0] data_v;
  logic [MAXC-1:0][DATA_W-1:0] mask_v;
  logic [MAXC-1:0][DATA_W-1:0] ecap_v;
  logic [MAXC-1:0]             pend;

  assign bank    = bus.address[3:2];
  assign ch      = bus.address[1:0];
  assign wr_en   = bus.chipselect & bus.write;
  assign edge_en = (prime == 2'd3);

  // Hold off edge detection until the sync pipe holds post-reset levels
  always_ff @(posedge clk) begin
    if (reset) begin
      prime <= 2'd0;
    end else if (prime != 2'd3) begin
      prime <= prime + 2'd1;
    end
  end

  for (genvar c = 0; c < MAXC; c++) begin : g_ch
    if (c < NUM_CH) begin : g_on
      word_t raw;
      word_t s2;
      word_t prev;
      word_t mask;
      word_t ecap;
      word_t rise;
      word_t fall;
      word_t det;
      word_t clr;

      assign raw = in_port[c*DATA_W +: DATA_W];

      if (SYNC_EN != 0) begin : g_sync
        word_t s1;
        // Two-flop synchroniser on the raw channel input
        always_ff @(posedge clk) begin
          if (reset) begin
            s1 <= '0;
            s2 <= '0;
          end else begin
            s1 <= raw;
            s2 <= s1;
          end
        end
      end else begin : g_nosync
        assign s2 = raw;
      end

      assign rise = s2 & ~prev;
      assign fall = ~s2 & prev;

      // Edge select; a set bit in both rise and fall is impossible
      always_comb begin
        det = '0;
        if (edge_en) begin
          if (EDGE_TYPE != 1) det = det | rise;
          if (EDGE_TYPE != 0) det = det | fall;
        end
      end

      assign clr = (wr_en && bank == BANK_EC && ch == 2'(c))
                 ? bus.writedata[DATA_W-1:0] : '0;

      // Previous level, mask register and sticky capture bits
      always_ff @(posedge clk) begin
        if (reset) begin
          prev <= '0;
          mask <= '0;
          ecap <= '0;
        end else begin
          prev <= s2;
          if (wr_en && bank == BANK_MASK && ch == 2'(c)) begin
            mask <= bus.writedata[DATA_W-1:0];
          end
          ecap <= (ecap & ~clr) | det;
        end
      end

      assign data_v[c] = s2;
      assign mask_v[c] = mask;
      assign ecap_v[c] = ecap;
      assign pend[c]   = |(ecap & mask);
    end else begin : g_off
      assign data_v[c] = '0;
      assign mask_v[c] = '0;
      assign ecap_v[c] = '0;
      assign pend[c]   = 1'b0;
    end
  end

  // Read mux; absent channels are tied to zero above
  always_comb begin
    rd_n = '0;
    unique case (bank)
      BANK_DATA: rd_n = 32'(data_v[ch]);
      BANK_MASK: rd_n = 32'(mask_v[ch]);
      BANK_EC:   rd_n = 32'(ecap_v[ch]);
      BANK_STAT: rd_n = 32'(pend);
      default:   rd_n = '0;
    endcase
  end

  // Registered read data and level interrupt
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.readdata <= '0;
      irq          <= 1'b0;
    end else begin
      bus.readdata <= rd_n;
      irq          <= |pend;
    end
  end

endmodule

// File: tb/tb_soc_system_pio_capture.sv
// Directed bench for the capture PIO, configured
// with two channels so out-of-range channels are exercised.
module tb_soc_system_pio_capture;

  localparam int NUM_CH = 2;
  localparam int DATA_W = 32;

  localparam logic [1:0] B_DATA = 2'b00;
  localparam logic [1:0] B_MASK = 2'b01;
  localparam logic [1:0] B_EC   = 2'b10;
  localparam logic [1:0] B_STAT = 2'b11;

  logic clk;
  logic reset;
  logic [NUM_CH*DATA_W-1:0] in_port;
  logic irq;

  int n_chk;
  int n_fail;

  soc_system_pio_capture_if bus ();

  soc_system_pio_capture #(
    .NUM_CH(NUM_CH),
    .DATA_W(DATA_W),
    .EDGE_TYPE(0),
    .SYNC_EN(1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .in_port(in_port),
    .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [1:0]  bank;
    logic [1:0]  ch;
    bit          do_wr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_irq;
  } vec_t;

  vec_t vecs[11];

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic rd(logic [1:0] b, logic [1:0] c,
                    output logic [31:0] v);
    bus.address    = {b, c};
    bus.chipselect = 1'b0;
    bus.write      = 1'b0;
    cyc();
    v = bus.readdata;
  endtask

  task automatic wr(logic [1:0] b, logic [1:0] c, logic [31:0] d);
    bus.address    = {b, c};
    bus.chipselect = 1'b1;
    bus.write      = 1'b1;
    bus.writedata  = d;
    cyc();
    bus.chipselect = 1'b0;
    bus.write      = 1'b0;
  endtask

  initial begin
    logic [31:0] v;
    n_chk  = 0;
    n_fail = 0;

    vecs[0]  = '{"mask0_wr",    B_MASK, 2'd0, 1, 32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0};
    vecs[1]  = '{"mask1_wr",    B_MASK, 2'd1, 1, 32'h00000001, 32'h00000001, 1'b0};
    vecs[2]  = '{"mask3_oor",   B_MASK, 2'd3, 1, 32'hFFFFFFFF, 32'h00000000, 1'b0};
    vecs[3]  = '{"mask2_oor",   B_MASK, 2'd2, 1, 32'hFFFFFFFF, 32'h00000000, 1'b0};
    vecs[4]  = '{"mask0_keep",  B_MASK, 2'd0, 0, 32'h0,        32'hA5A5A5A5, 1'b0};
    vecs[5]  = '{"mask1_keep",  B_MASK, 2'd1, 0, 32'h0,        32'h00000001, 1'b0};
    vecs[6]  = '{"data_ro",     B_DATA, 2'd0, 1, 32'h00000000, 32'hFFFFFFFF, 1'b0};
    vecs[7]  = '{"stat_ro",     B_STAT, 2'd0, 1, 32'hFFFFFFFF, 32'h00000000, 1'b0};
    vecs[8]  = '{"data3_oor",   B_DATA, 2'd3, 0, 32'h0,        32'h00000000, 1'b0};
    vecs[9]  = '{"ec2_oor",     B_EC,   2'd2, 0, 32'h0,        32'h00000000, 1'b0};
    vecs[10] = '{"mask0_clr",   B_MASK, 2'd0, 1, 32'h00000000, 32'h00000000, 1'b0};

    reset          = 1'b1;
    in_port        = '1;
    bus.address    = '0;
    bus.chipselect = 1'b0;
    bus.write      = 1'b0;
    bus.writedata  = '0;

    // Reset with all inputs high
    repeat (5) cyc();
    chk("rst_irq", 32'(irq), 32'h0);
    chk("rst_rdata", bus.readdata, 32'h0);
    reset = 1'b0;
    repeat (5) cyc();
    rd(B_DATA, 2'd0, v);
    chk("rel_data0", v, 32'hFFFFFFFF);
    rd(B_EC, 2'd0, v);
    chk("rel_ec0", v, 32'h0);
    rd(B_EC, 2'd1, v);
    chk("rel_ec1", v, 32'h0);
    chk("rel_irq", 32'(irq), 32'h0);

    // Register map vectors
    for (int i = 0; i < 11; i++) begin
      if (vecs[i].do_wr) wr(vecs[i].bank, vecs[i].ch, vecs[i].wdata);
      rd(vecs[i].bank, vecs[i].ch, v);
      chk(vecs[i].name, v, vecs[i].exp_rd);
      chk({vecs[i].name, "_irq"}, 32'(irq), 32'(vecs[i].exp_irq));
    end

    // Falling edges ignored with rising-edge capture
    in_port[63:32] = 32'h0;
    repeat (5) cyc();
    rd(B_EC, 2'd1, v);
    chk("fall_ignored", v, 32'h0);
    chk("fall_irq", 32'(irq), 32'h0);

    // Rising edge on ch1 bit0 and its latency
    in_port[32] = 1'b1;
    cyc();
    cyc();
    cyc();
    chk("rise_ec_t3", bus.readdata, 32'h0);
    chk("rise_irq_t3", 32'(irq), 32'h0);
    cyc();
    chk("rise_ec_t4", bus.readdata, 32'h1);
    cyc();
    chk("rise_irq_t5", 32'(irq), 32'h1);

    in_port[32] = 1'b0;
    repeat (5) cyc();
    rd(B_EC, 2'd1, v);
    chk("fall_sticky", v, 32'h1);
    chk("fall_sticky_irq", 32'(irq), 32'h1);

    // W1C in the same cycle as a new edge: edge wins
    in_port[32] = 1'b1;
    cyc();
    cyc();
    bus.chipselect = 1'b1;
    bus.write      = 1'b1;
    bus.writedata  = 32'h1;
    cyc();
    bus.chipselect = 1'b0;
    bus.write      = 1'b0;
    cyc();
    cyc();
    chk("w1c_race_ec", bus.readdata, 32'h1);
    chk("w1c_race_irq", 32'(irq), 32'h1);

    // Plain W1C clears, irq drops the following cycle
    bus.chipselect = 1'b1;
    bus.write      = 1'b1;
    bus.writedata  = 32'h1;
    cyc();
    bus.chipselect = 1'b0;
    bus.write      = 1'b0;
    chk("w1c_irq_e0", 32'(irq), 32'h1);
    cyc();
    chk("w1c_ec", bus.readdata, 32'h0);
    chk("w1c_irq_e1", 32'(irq), 32'h0);

    // Capture under mask 0, then unmask
    in_port[4] = 1'b0;
    repeat (5) cyc();
    in_port[4] = 1'b1;
    repeat (5) cyc();
    rd(B_EC, 2'd0, v);
    chk("masked_ec0", v, 32'h10);
    chk("masked_irq", 32'(irq), 32'h0);
    rd(B_STAT, 2'd0, v);
    chk("masked_stat", v, 32'h0);
    wr(B_MASK, 2'd0, 32'h10);
    chk("unmask_irq_e0", 32'(irq), 32'h0);
    rd(B_STAT, 2'd0, v);
    chk("unmask_stat", v, 32'h1);
    chk("unmask_irq_e1", 32'(irq), 32'h1);
    rd(B_EC, 2'd0, v);
    chk("unmask_ec0", v, 32'h10);

    // Reset mid-operation with a write during reset
    reset          = 1'b1;
    bus.address    = {B_MASK, 2'd1};
    bus.chipselect = 1'b1;
    bus.write      = 1'b1;
    bus.writedata  = 32'hFFFFFFFF;
    cyc();
    chk("mid_rst_irq", 32'(irq), 32'h0);
    chk("mid_rst_rdata", bus.readdata, 32'h0);
    cyc();
    cyc();
    bus.chipselect = 1'b0;
    bus.write      = 1'b0;
    reset          = 1'b0;
    repeat (6) cyc();
    rd(B_MASK, 2'd1, v);
    chk("post_mask1", v, 32'h0);
    rd(B_MASK, 2'd0, v);
    chk("post_mask0", v, 32'h0);
    rd(B_EC, 2'd0, v);
    chk("post_ec0", v, 32'h0);
    rd(B_EC, 2'd1, v);
    chk("post_ec1", v, 32'h0);
    rd(B_STAT, 2'd0, v);
    chk("post_stat", v, 32'h0);
    chk("post_irq", 32'(irq), 32'h0);
    wr(B_MASK, 2'd0, 32'hFFFFFFFF);
    cyc();
    cyc();
    chk("post_no_spur", 32'(irq), 32'h0);

    // DATA path latency through the synchroniser
    rd(B_DATA, 2'd1, v);
    chk("data1_before", v, 32'h1);
    in_port[63:32] = 32'h12345679;
    cyc();
    cyc();
    chk("data_lat_t2", bus.readdata, 32'h1);
    cyc();
    chk("data_lat_t3", bus.readdata, 32'h12345679);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
